// File: rtl/rr_evaluation_unit_lockable_if.sv
// Allocator bundle: per-input request groups, lock and tail-release
// bits in; registered one-hot grant, id, lock and timeout status out.
interface rr_evaluation_unit_lockable_if #(
  parameter int P_INPUTS   = 5,
  parameter int P_CHANNELS = 4,
  parameter int P_ID_W     = 3
);
  logic [P_INPUTS*P_CHANNELS-1:0] request_flat;
  logic [P_INPUTS-1:0]            lock_req;
  logic [P_INPUTS-1:0]            tail_release;
  logic [P_INPUTS-1:0]            grant_vector;
  logic                           grant_valid;
  logic [P_ID_W-1:0]              grant_id;
  logic                           locked;
  logic                           timeout_flag;

  modport master (
    output request_flat, lock_req, tail_release,
    input  grant_vector, grant_valid, grant_id,
    input  locked, timeout_flag
  );

  modport slave (
    input  request_flat, lock_req, tail_release,
    output grant_vector, grant_valid, grant_id,
    output locked, timeout_flag
  );
endinterface

// File: rtl/rr_evaluation_unit_lockable.sv
// Round-robin matrix allocator for one output channel with lock-until-tail.
// Ports: CLK, RST (async, active-low), bus (slave): request_flat,
// lock_req, tail_release in; grant_vector/valid/id, locked,
// timeout_flag out. Macro RR_HOLD_TIMEOUT_EN adds a lock timeout.
module rr_evaluation_unit_lockable #(
  parameter int P_ROUTER_ID  = 0,
  parameter int P_CHANNEL_ID = 0,
  parameter int P_INPUTS     = 5,
  parameter int P_CHANNELS   = 4,
  parameter int P_ID_W       = 3,
  parameter int P_HOLD_MAX   = 16
) (
  input logic CLK,
  input logic RST,
  rr_evaluation_unit_lockable_if.slave bus
);

  if (P_INPUTS < 2 || P_INPUTS > 16 ||
      P_CHANNELS < 1 ||
      P_ID_W < $clog2(P_INPUTS) ||
      P_HOLD_MAX < 2 ||
      P_ROUTER_ID < 0 ||
      P_CHANNEL_ID < 0) begin : g_bad_param
    $error("rr_evaluation_unit_lockable: invalid parameters");
  end

  typedef enum logic {
    S_IDLE,
    S_LOCKED
  } state_t;

  state_t              state;
  logic [P_INPUTS-1:0] gvec;
  logic [P_ID_W-1:0]   gid;
  logic                tflag;

  // prio[i][j] = 1 means input i beats input j
  logic [P_INPUTS-1:0] prio [P_INPUTS];

  logic [P_INPUTS-1:0] req;
  logic [P_INPUTS-1:0] win;
  logic [P_ID_W-1:0]   win_id;
  logic                own_rel;
  logic                lock_w;
  logic                forced;
  logic                arb;

  always_comb begin
    req = '0;
    for (int i = 0; i < P_INPUTS; i++)
      req[i] = |bus.request_flat[i*P_CHANNELS +: P_CHANNELS];
  end

  always_comb begin
    win = '0;
    for (int i = 0; i < P_INPUTS; i++) begin
      win[i] = req[i];
      for (int j = 0; j < P_INPUTS; j++)
        if (!(i == j || !req[j] || prio[i][j]))
          win[i] = 1'b0;
    end
  end

  always_comb begin
    win_id = '0;
    for (int i = 0; i < P_INPUTS; i++)
      if (win[i])
        win_id = win_id | P_ID_W'(i);
  end

  // the grant register doubles as the lock owner
  assign own_rel = (state == S_LOCKED) &&
                   |(gvec & bus.tail_release);
  assign lock_w  = |(win & bus.lock_req);

`ifdef RR_HOLD_TIMEOUT_EN
  localparam int CNT_W = $clog2(P_HOLD_MAX) + 1;

  logic [CNT_W-1:0] cnt;

  assign forced = (state == S_LOCKED) && !own_rel &&
                  (cnt == CNT_W'(P_HOLD_MAX - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
    end else if (state == S_IDLE || own_rel || forced) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign forced = 1'b0;
`endif

  assign arb = (state == S_IDLE) || own_rel || forced;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= S_IDLE;
      gvec  <= '0;
      gid   <= '0;
      tflag <= 1'b0;
      for (int i = 0; i < P_INPUTS; i++)
        for (int j = 0; j < P_INPUTS; j++)
          prio[i][j] <= (i < j);
    end else begin
      tflag <= forced;
      if (arb) begin
        gvec <= win;
        gid  <= win_id;
        if (|win && lock_w)
          state <= S_LOCKED;
        else
          state <= S_IDLE;
        // winner drops to lowest priority
        for (int i = 0; i < P_INPUTS; i++)
          for (int j = 0; j < P_INPUTS; j++)
            if (win[i])
              prio[i][j] <= 1'b0;
            else if (win[j])
              prio[i][j] <= 1'b1;
      end
    end
  end

  assign bus.grant_vector = gvec;
  assign bus.grant_valid  = |gvec;
  assign bus.grant_id     = gid;
  assign bus.locked       = (state == S_LOCKED);
  assign bus.timeout_flag = tflag;

endmodule

// File: tb/tb_rr_evaluation_unit_lockable.sv
// Bench for rr_evaluation_unit_lockable: directed steps with an
// LRU-order model feeding a one-deep expected-result queue.
module tb_rr_evaluation_unit_lockable;
  localparam int N = 5;
  localparam int C = 4;
  localparam int W = 3;
  localparam int H = 16;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  rr_evaluation_unit_lockable_if #(
    .P_INPUTS(N), .P_CHANNELS(C), .P_ID_W(W)
  ) bus ();

  rr_evaluation_unit_lockable #(
    .P_ROUTER_ID(0), .P_CHANNEL_ID(0),
    .P_INPUTS(N), .P_CHANNELS(C),
    .P_ID_W(W), .P_HOLD_MAX(H)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct packed {
    logic [N-1:0] vec;
    logic [W-1:0] id;
    logic         valid;
    logic         lck;
    logic         tf;
  } exp_t;

  exp_t sb[$];
  int   order[$];
  bit   m_lck;
  int   m_own;
  int   m_cnt;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vec"}, 32'(bus.grant_vector), 0);
    chk({tag, "_valid"}, 32'(bus.grant_valid), 0);
    chk({tag, "_id"}, 32'(bus.grant_id), 0);
    chk({tag, "_locked"}, 32'(bus.locked), 0);
    chk({tag, "_tflag"}, 32'(bus.timeout_flag), 0);
  endtask

  task automatic model_reset();
    order = {0, 1, 2, 3, 4};
    m_lck = 1'b0;
    m_own = 0;
    m_cnt = 0;
    sb.delete();
  endtask

  task automatic set_req(input logic [N-1:0] r);
    for (int i = 0; i < N; i++)
      bus.request_flat[i*C +: C] = r[i] ? C'(i + 1) : '0;
  endtask

  // Predict the outputs that the coming clock edge produces.
  task automatic model_push();
    exp_t e;
    bit   rel;
    bit   frc;
    int   w;
    int   idx;
    e   = '0;
    rel = m_lck && bus.tail_release[m_own];
    frc = 1'b0;
`ifdef RR_HOLD_TIMEOUT_EN
    frc = m_lck && !rel && (m_cnt == H - 1);
`endif
    if (!m_lck || rel || frc) begin
      w   = -1;
      idx = 0;
      foreach (order[k])
        if (w < 0 && bus.request_flat[order[k]*C +: C] != '0) begin
          w   = order[k];
          idx = k;
        end
      if (w >= 0) begin
        order.delete(idx);
        order.push_back(w);
        e.vec   = N'(1) << w;
        e.id    = W'(w);
        e.valid = 1'b1;
        m_lck   = bus.lock_req[w];
        m_own   = w;
        m_cnt   = 0;
      end else begin
        m_lck = 1'b0;
      end
      e.tf = frc;
    end else begin
      m_cnt++;
      e.vec   = N'(1) << m_own;
      e.id    = W'(m_own);
      e.valid = 1'b1;
    end
    e.lck = m_lck;
    sb.push_back(e);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle();
    exp_t e;
    model_push();
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    chk("grant_vector", 32'(bus.grant_vector), 32'(e.vec));
    chk("grant_valid", 32'(bus.grant_valid), 32'(e.valid));
    chk("grant_id", 32'(bus.grant_id), 32'(e.id));
    chk("locked", 32'(bus.locked), 32'(e.lck));
    chk("timeout_flag", 32'(bus.timeout_flag), 32'(e.tf));
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b0;
    #1;
    chk_zero("reset");
    model_reset();
    @(negedge CLK);
    RST = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t2 [6];
    t2 = '{0, 1, 2, 3, 4, 0};
    bus.request_flat = '0;
    bus.lock_req     = '0;
    bus.tail_release = '0;
    model_reset();
    #2;
    chk_zero("por");
    @(negedge CLK);
    RST = 1'b1;

    // groups 0 and 2 alternate
    set_req(5'b00101);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("t1_alt", 32'(bus.grant_id), (k % 2 == 0) ? 0 : 2);
    end

    // all inputs, fair rotation from reset priority
    set_req('0);
    do_reset();
    set_req(5'b11111);
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("t2_rot", 32'(bus.grant_id), 32'(t2[k]));
    end

    // move 1 and 2 behind 3, then lock 3
    set_req(5'b00110);
    cycle();
    cycle();
    set_req(5'b11010);
    bus.lock_req = 5'b01000;
    cycle();
    chk("t3_lock_id", 32'(bus.grant_id), 3);
    chk("t3_lock", 32'(bus.locked), 1);
    bus.lock_req = '0;
    cycle();
    cycle();
    bus.tail_release = 5'b00010;
    cycle();
    chk("t3_nonowner", 32'(bus.grant_id), 3);
    bus.tail_release = '0;
    cycle();
    bus.tail_release = 5'b01000;
    cycle();
    chk("t3_after_rel", 32'(bus.grant_id), 4);
    chk("t3_unlocked", 32'(bus.locked), 0);
    bus.tail_release = '0;
    cycle();
    chk("t3_next", 32'(bus.grant_id), 1);

    // owner request drops, lock persists
    set_req(5'b00100);
    bus.lock_req = 5'b00100;
    cycle();
    bus.lock_req = '0;
    set_req(5'b00001);
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("t4_hold_id", 32'(bus.grant_id), 2);
      chk("t4_hold_lock", 32'(bus.locked), 1);
    end
    bus.tail_release = 5'b00100;
    cycle();
    chk("t4_rel", 32'(bus.grant_id), 0);
    bus.tail_release = '0;

`ifdef RR_HOLD_TIMEOUT_EN
    // lock times out after H granted cycles
    set_req('0);
    do_reset();
    set_req(5'b00010);
    bus.lock_req = 5'b00010;
    cycle();
    bus.lock_req = '0;
    set_req(5'b00001);
    for (int k = 0; k < H - 1; k++) begin
      cycle();
      chk("t5_hold", 32'(bus.grant_id), 1);
    end
    cycle();
    chk("t5_moved", 32'(bus.grant_id), 0);
    chk("t5_tflag", 32'(bus.timeout_flag), 1);
    cycle();
    chk("t5_tflag_off", 32'(bus.timeout_flag), 0);
`else
    // without the timeout the lock never expires
    set_req(5'b00010);
    bus.lock_req = 5'b00010;
    cycle();
    bus.lock_req = '0;
    set_req(5'b00001);
    for (int k = 0; k < H + 4; k++)
      cycle();
    chk("t5_no_timeout", 32'(bus.locked), 1);
    chk("t5_no_tflag", 32'(bus.timeout_flag), 0);
    bus.tail_release = 5'b00010;
    cycle();
    bus.tail_release = '0;
`endif

    // reset in the middle of a lock
    set_req(5'b01000);
    bus.lock_req = 5'b01000;
    cycle();
    bus.lock_req = '0;
    cycle();
    chk("t6_locked", 32'(bus.locked), 1);
    #2;
    set_req(5'b11111);
    do_reset();
    cycle();
    chk("t6_first", 32'(bus.grant_id), 0);
    cycle();
    chk("t6_second", 32'(bus.grant_id), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
